// File: rtl/pad_input_filter_bank.sv
// Purpose: bank of input-only pad channels: synchroniser, glitch filter, edge pulses, sticky OE-violation flag.
// Latency: pad -> pad_out_o in SYNC_STAGES+1+filter_thr_i cycles (SYNC_STAGES+1 in bypass); edge pulses one cycle later.
// Backpressure: none; every channel is free-running and samples its pad on every clock.
//
// Ports:
//   clk_i, rst_ni       clock and asynchronous active-low reset
//   pad_io              pad wires, never driven by this block (permanent high-Z)
//   pad_oe_i            per-pad output-enable request; any 1 is recorded as a violation
//   pad_attributes_i    per-pad attributes, carried for interface compatibility only
//   filter_en_i         1 = glitch filter active, 0 = bypass (shared by all channels)
//   filter_thr_i        extra consecutive samples needed to accept a level change (shared)
//   pad_out_o           filtered pad level
//   rise_o / fall_o     one-cycle pulses, the cycle after pad_out_o goes 0->1 / 1->0
//   oe_err_o            sticky per-channel OE violation
//   oe_err_clr_i        clears all oe_err_o bits whose pad_oe_i is low
//   OE_ERR_REPORT       1 = emit a simulation message when an OE violation flag first sets

module pad_input_filter_bank #(
  parameter int NPADS         = 8,
  parameter int PADATTR       = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_W      = 4,
  parameter bit OE_ERR_REPORT = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  inout  wire  [NPADS-1:0]           pad_io,
  input  logic [NPADS-1:0]           pad_oe_i,
  input  logic [NPADS*PADATTR-1:0]   pad_attributes_i,
  input  logic                       filter_en_i,
  input  logic [FILTER_W-1:0]        filter_thr_i,
  output logic [NPADS-1:0]           pad_out_o,
  output logic [NPADS-1:0]           rise_o,
  output logic [NPADS-1:0]           fall_o,
  output logic [NPADS-1:0]           oe_err_o,
  input  logic                       oe_err_clr_i
);

  // This block only ever observes the pads.
  assign pad_io = {NPADS{1'bz}};

  // Attributes are accepted but have no effect on an input-only cell.
  logic unused_attr;
  assign unused_attr = ^pad_attributes_i;

  // ------------------------------------------------------------------
  // Per-channel state
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q [NPADS];
  logic [FILTER_W-1:0]    cnt_q  [NPADS];
  logic [FILTER_W-1:0]    cnt_d  [NPADS];

  logic [NPADS-1:0] samp;          // last synchroniser stage
  logic [NPADS-1:0] stable_q;      // accepted (filtered) level
  logic [NPADS-1:0] stable_d;
  logic [NPADS-1:0] stable_dly_q;  // stable_q one cycle late, for edge detect
  logic [NPADS-1:0] rise_q;
  logic [NPADS-1:0] fall_q;
  logic [NPADS-1:0] oe_err_q;
  logic [NPADS-1:0] oe_err_d;

  // ------------------------------------------------------------------
  // Filter next-state
  // A change is accepted once cnt has already reached the threshold
  // while the sample still disagrees, i.e. after thr+1 consecutive
  // mismatching samples. Because cnt is only incremented while it is
  // below the threshold it can never wrap, and lowering the threshold
  // mid-count takes effect on the very next compare.
  // ------------------------------------------------------------------
  always_comb begin
    samp     = '0;
    stable_d = stable_q;
    for (int i = 0; i < NPADS; i++) begin
      samp[i]  = sync_q[i][SYNC_STAGES-1];
      cnt_d[i] = '0;
      if (!filter_en_i) begin
        // Bypass: follow the synchroniser, discard any partial count.
        stable_d[i] = samp[i];
      end else if (samp[i] != stable_q[i]) begin
        if (cnt_q[i] >= filter_thr_i) begin
          stable_d[i] = samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // A matching sample leaves cnt_d at zero, restarting the count.
    end
  end

  // Set has priority over clear so a request present in the clear cycle
  // is never lost.
  assign oe_err_d = pad_oe_i | (oe_err_q & ~{NPADS{oe_err_clr_i}});

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPADS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q     <= '0;
      stable_dly_q <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      oe_err_q     <= '0;
    end else begin
      for (int i = 0; i < NPADS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad_io[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q     <= stable_d;
      // Edges are taken between stable_q and its delayed copy, so the
      // pulse lands in the cycle after pad_out_o changes. Both copies
      // reset to 0, so leaving reset never produces a pulse.
      stable_dly_q <= stable_q;
      rise_q       <= stable_q & ~stable_dly_q;
      fall_q       <= ~stable_q & stable_dly_q;
      oe_err_q     <= oe_err_d;
    end
  end

  assign pad_out_o = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign oe_err_o  = oe_err_q;

  // ------------------------------------------------------------------
  // Simulation-only report on the 0->1 transition of an OE flag.
  // Reported as an error, never a stop, so the run continues.
  // ------------------------------------------------------------------
  always @(posedge clk_i) begin
    if (OE_ERR_REPORT && rst_ni) begin
      for (int i = 0; i < NPADS; i++) begin
        if (pad_oe_i[i] && !oe_err_q[i]) begin
          $error("pad_input_filter_bank: output enable requested on input-only pad %0d", i);
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_input_filter_bank.sv
module tb_pad_input_filter_bank;

  localparam int NPADS       = 8;
  localparam int PADATTR     = 16;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_W    = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NPADS-1:0]         pad_drv;
  wire  [NPADS-1:0]         pad_w;
  logic [NPADS-1:0]         pad_oe;
  logic [NPADS*PADATTR-1:0] attrs;
  logic                     filter_en;
  logic [FILTER_W-1:0]      thr;
  logic [NPADS-1:0]         pad_out;
  logic [NPADS-1:0]         rise;
  logic [NPADS-1:0]         fall;
  logic [NPADS-1:0]         oe_err;
  logic                     oe_clr;

  assign pad_w = pad_drv;

  // Intentional OE violations are exercised, so the design's own report is muted.
  pad_input_filter_bank #(
    .NPADS(NPADS), .PADATTR(PADATTR), .SYNC_STAGES(SYNC_STAGES),
    .FILTER_W(FILTER_W), .OE_ERR_REPORT(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_io(pad_w), .pad_oe_i(pad_oe),
    .pad_attributes_i(attrs), .filter_en_i(filter_en), .filter_thr_i(thr),
    .pad_out_o(pad_out), .rise_o(rise), .fall_o(fall), .oe_err_o(oe_err),
    .oe_err_clr_i(oe_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [NPADS-1:0] obs, input logic [NPADS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: each pad sample reaches the filter SYNC_STAGES
  // clocks after it was taken; a level is accepted once it has been
  // seen on thr+1 consecutive samples (immediately in bypass); edges
  // show up one clock after the accepted level moves.
  // ------------------------------------------------------------------
  logic [NPADS-1:0] m_pipe[$];
  logic [NPADS-1:0] m_out, m_prev, m_rise, m_fall, m_oe;
  int               m_run [NPADS];

  task automatic model_reset();
    m_pipe = {};
    for (int k = 0; k < SYNC_STAGES; k++) m_pipe.push_back('0);
    m_out = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_oe = '0;
    for (int i = 0; i < NPADS; i++) m_run[i] = 0;
  endtask

  task automatic model_update();
    logic [NPADS-1:0] s;
    s = m_pipe.pop_front();
    m_pipe.push_back(pad_drv);
    m_rise = m_out & ~m_prev;
    m_fall = ~m_out & m_prev;
    m_prev = m_out;
    for (int i = 0; i < NPADS; i++) begin
      if (s[i] == m_out[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (!filter_en || m_run[i] >= int'(thr) + 1) begin
          m_out[i] = s[i];
          m_run[i] = 0;
        end
      end
    end
    m_oe = pad_oe | (oe_clr ? '0 : m_oe);
  endtask

  task automatic check_model();
    chk("model_pad_out", pad_out, m_out);
    chk("model_rise",    rise,    m_rise);
    chk("model_fall",    fall,    m_fall);
    chk("model_oe_err",  oe_err,  m_oe);
  endtask

  // Advance one clock: model follows the same edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    else model_reset();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst_n     = 1'b0;
    pad_drv   = '1;
    pad_oe    = '0;
    oe_clr    = 1'b0;
    filter_en = 1'b0;
    thr       = '0;
    attrs     = {4{$urandom()}};
    model_reset();

    // Reset with pads high: everything held at 0.
    repeat (3) begin
      step();
      chk("reset_pad_out", pad_out, '0);
      chk("reset_oe_err", oe_err, '0);
    end

    // Reset exit: level appears at cycle SYNC_STAGES+1, single rise after.
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("rstexit_pad_out", pad_out, (c >= SYNC_STAGES + 1) ? '1 : '0);
      chk("rstexit_rise", rise, (c == SYNC_STAGES + 2) ? '1 : '0);
    end

    pad_drv = '0;
    repeat (8) step();

    // Bypass: pad0 rises, visible 3 cycles later, pulse at cycle 4.
    pad_drv[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("bypass_pad_out", pad_out, (c >= 3) ? 8'h01 : 8'h00);
      chk("bypass_rise", rise, (c == 4) ? 8'h01 : 8'h00);
    end

    // Glitch rejection: 3-cycle pulse on pad1 with thr=3 is ignored.
    filter_en = 1'b1;
    thr = 4'd3;
    pad_drv[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("glitch_pad_out", pad_out, 8'h01);
      chk("glitch_rise", rise, 8'h00);
      pad_drv[1] = (c < 3);
    end

    // 4-cycle pulse is accepted at cycle 6, pulse at cycle 7.
    pad_drv[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("accept_pad_out", pad_out, (c >= 6) ? 8'h03 : 8'h01);
      chk("accept_rise", rise, (c == 7) ? 8'h02 : 8'h00);
      pad_drv[1] = (c < 4);
    end
    repeat (10) step();

    // thr=0 with the filter enabled matches bypass latency.
    thr = 4'd0;
    pad_drv[4] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("thr0_pad_out", pad_out, (c >= 3) ? 8'h11 : 8'h01);
      chk("thr0_rise", rise, (c == 4) ? 8'h10 : 8'h00);
    end

    // Maximum threshold: 16 samples needed, no counter wrap.
    thr = 4'hF;
    pad_drv[5] = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      chk("thrmax_pad_out", pad_out, (c >= 18) ? 8'h31 : 8'h11);
      chk("thrmax_rise", rise, (c == 19) ? 8'h20 : 8'h00);
    end

    // OE violation: set, hold, set beats clear, clear alone.
    pad_oe[2] = 1'b1;
    step();
    chk("oe_set", oe_err, 8'h04);
    pad_oe = '0;
    step();
    chk("oe_hold", oe_err, 8'h04);
    pad_oe[2] = 1'b1;
    oe_clr = 1'b1;
    step();
    chk("oe_set_wins", oe_err, 8'h04);
    pad_oe = '0;
    step();
    chk("oe_clear", oe_err, 8'h00);
    oe_clr = 1'b0;
    step();
    chk("oe_stay_clear", oe_err, 8'h00);

    // Reset mid-filter: pad3 counting with thr=5, reset drops outputs at once.
    thr = 4'd5;
    pad_drv[3] = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_pad_out", pad_out, 8'h00);
    chk("midrst_rise", rise, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    // Pads 0,3,4,5 are high; full 6-sample acceptance after the 2-stage sync.
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("midrst_restart_out", pad_out, (c >= 8) ? 8'h39 : 8'h00);
      chk("midrst_restart_rise", rise, (c == 9) ? 8'h39 : 8'h00);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NPADS; i++) begin
        if ($urandom_range(0, 7) == 0) pad_drv[i] = ~pad_drv[i];
        pad_oe[i] = ($urandom_range(0, 63) == 0);
      end
      if ($urandom_range(0, 47) == 0) thr = FILTER_W'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) thr = 4'hF;
      if ($urandom_range(0, 99) == 0) filter_en = ~filter_en;
      oe_clr = ($urandom_range(0, 15) == 0);
      if (n == 700) begin
        #2 rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
